// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter and UART frame sequencer sharing one tx line among NUM_REQ requesters.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            enb_tx,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   data_in,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [$clog2(NUM_REQ)-1:0]      owner,
    output logic                            busy,
    output logic                            done,
    output logic                            tx
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(DATA_WIDTH + 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        STOP   = 3'd5
    } state_t;
`endif

    state_t                 state_q, state_d;
    logic [OW-1:0]          owner_q, owner_d;
    logic [OW-1:0]          last_q, last_d;
    logic [DATA_WIDTH-1:0]  shreg_q, shreg_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic                   tx_q, tx_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic                   done_q, done_d;
    logic                   busy_q;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    logic [DATA_WIDTH-1:0]  req_data [NUM_REQ];
    logic [OW-1:0]          winner;
    logic                   found;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign req_data[g] = data_in[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Handshake: a requester holds req high until it sees its one-cycle gnt pulse; gnt marks
    // the cycle after its byte was captured. Dropping req before gnt withdraws the request.
    always_comb begin
        found  = 1'b0;
        winner = last_q;
        for (int i = 1; i <= NUM_REQ; i++) begin
            int            idx;
            logic [OW-1:0] cand;
            idx = int'(last_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = OW'(idx);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        gnt_d     = '0;
        done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        unique case (state_q)
            IDLE: begin
                // Ticks are ignored here so the start bit always waits for a fresh tick in ARM.
                tx_d = 1'b1;
                if (found) begin
                    shreg_d       = req_data[winner];
                    owner_d       = winner;
                    gnt_d[winner] = 1'b1;
                    state_d       = ARM;
`ifdef UART_TX_PARITY_EN
                    parity_d      = ^req_data[winner];
`endif
                end
            end
            ARM: begin
                if (enb_tx) begin
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (enb_tx) begin
                    tx_d      = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = CW'(1);
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (enb_tx) begin
                    if (bit_cnt_q < CW'(DATA_WIDTH)) begin
                        tx_d      = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (enb_tx) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // Rotation only advances once a frame fully completes.
                if (enb_tx) begin
                    done_d  = 1'b1;
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            last_q    <= OW'(NUM_REQ - 1);
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            busy_q    <= (state_d != IDLE);
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a line-level queue model checked every cycle,
// plus literal frame, grant-order and reset expectations.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int OW         = $clog2(NUM_REQ);
`ifdef UART_TX_PARITY_EN
    localparam int FT = DATA_WIDTH + 4;
`else
    localparam int FT = DATA_WIDTH + 3;
`endif
    // FT counts ticks from the start-bit tick up to and including the tick that ends the frame.

    logic                          clock = 1'b0;
    logic                          reset;
    logic                          enb_tx;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] data_in;
    logic [NUM_REQ-1:0]            gnt;
    logic [OW-1:0]                 owner;
    logic                          busy;
    logic                          done;
    logic                          tx;

    logic [DATA_WIDTH-1:0]         bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
        assign data_in[g*DATA_WIDTH +: DATA_WIDTH] = bytes[g];
    end

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) dut (
        .clock   (clock),
        .reset   (reset),
        .enb_tx  (enb_tx),
        .req     (req),
        .data_in (data_in),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .done    (done),
        .tx      (tx)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: a frame is a queue of line levels, one popped per tick.
    logic [0:0]         exp_q [$];
    logic               m_busy  = 1'b0;
    logic               m_tx    = 1'b1;
    logic               m_done  = 1'b0;
    logic [NUM_REQ-1:0] m_gnt   = '0;
    logic [OW-1:0]      m_owner = '0;
    logic [OW-1:0]      m_last  = OW'(NUM_REQ - 1);
    logic [OW-1:0]      m_w;
    logic               m_found;

    int gnt_log [$];
    int owner_log [$];
    int tx_log [$];
    int exp_seq [$];
    int done_cnt = 0;

    function automatic void push_frame(input logic [DATA_WIDTH-1:0] b);
        exp_q.push_back(1'b0);
        for (int j = 0; j < DATA_WIDTH; j++) exp_q.push_back(b[j]);
`ifdef UART_TX_PARITY_EN
        exp_q.push_back(^b);
`endif
        exp_q.push_back(1'b1);
    endfunction

    function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy  = 1'b0;
            m_tx    = 1'b1;
            m_done  = 1'b0;
            m_gnt   = '0;
            m_owner = '0;
            m_last  = OW'(NUM_REQ - 1);
            exp_q.delete();
        end else begin
            m_gnt  = '0;
            m_done = 1'b0;
            if (!m_busy) begin
                m_tx    = 1'b1;
                m_found = 1'b0;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    if (!m_found && req[OW'((int'(m_last) + k) % NUM_REQ)]) begin
                        m_found = 1'b1;
                        m_w     = OW'((int'(m_last) + k) % NUM_REQ);
                    end
                end
                if (m_found) begin
                    m_busy     = 1'b1;
                    m_owner    = m_w;
                    m_gnt[m_w] = 1'b1;
                    push_frame(bytes[m_w]);
                end
            end else if (enb_tx) begin
                if (exp_q.size() > 0) begin
                    m_tx = exp_q.pop_front();
                end else begin
                    m_done = 1'b1;
                    m_busy = 1'b0;
                    m_last = m_owner;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        check("tx",    32'(tx),    32'(m_tx));
        check("busy",  32'(busy),  32'(m_busy));
        check("done",  32'(done),  32'(m_done));
        check("gnt",   32'(gnt),   32'(m_gnt));
        check("owner", 32'(owner), 32'(m_owner));
        if (gnt != '0) begin
            gnt_log.push_back(onehot_idx(gnt));
            owner_log.push_back(int'(owner));
        end
        if (done) done_cnt++;
    end

    task automatic tick_wait(input int n);
        for (int t = 0; t < n; t++) begin
            repeat (15) @(negedge clock);
            enb_tx = 1'b1;
            @(negedge clock);
            enb_tx = 1'b0;
            #1;
            tx_log.push_back(int'(tx));
        end
    endtask

    task automatic wait_gnt(input string name);
        int c;
        c = 0;
        while (gnt == '0 && c < 64) begin
            @(negedge clock);
            c++;
        end
        #1;
        check({name, "_gnt_seen"}, 32'(gnt != '0), 32'd1);
    endtask

    task automatic grant_one(input logic [NUM_REQ-1:0] mask, input string name);
        req = mask;
        wait_gnt(name);
        req = '0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        gnt_log.delete();
        owner_log.delete();
        tx_log.delete();
        done_cnt = 0;
    endtask

    task automatic compare_seq(input string name);
        for (int i = 0; i < exp_seq.size(); i++) begin
            if (i < tx_log.size())
                check($sformatf("%s_bit%0d", name, i), 32'(tx_log[i]), 32'(exp_seq[i]));
            else
                check($sformatf("%s_bit%0d_missing", name, i), 32'd0, 32'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int g0;
        reset  = 1'b1;
        enb_tx = 1'b0;
        req    = '0;
        for (int i = 0; i < NUM_REQ; i++) bytes[i] = '0;

        // reset state
        repeat (2) @(negedge clock);
        #1;
        check("rst_tx",    32'(tx),    32'd1);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_gnt",   32'(gnt),   32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // single frame, 0xA5 from requester 0
        bytes[0] = 8'hA5;
        grant_one(4'b0001, "single");
        tx_log.delete();
        d0 = done_cnt;
        tick_wait(FT - 1);
        check("single_no_early_done", 32'(done_cnt - d0), 32'd0);
        tick_wait(1);
        check("single_done_once", 32'(done_cnt - d0), 32'd1);
        check("single_gnt_count", 32'(gnt_log.size()), 32'd1);
        check("single_gnt_idx", 32'(gnt_log[0]), 32'd0);
        check("single_idle_busy", 32'(busy), 32'd0);
`ifdef UART_TX_PARITY_EN
        exp_seq = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
        exp_seq = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif
        compare_seq("single_a5");

        // fairness with all requests held after reset
        do_reset();
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
        req = 4'b1111;
        tick_wait(5 * FT);
        req = '0;
        tick_wait(2);
        check("fair_gnt_count", 32'(gnt_log.size()), 32'd5);
        check("fair_done_count", 32'(done_cnt), 32'd5);
        exp_seq = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            if (i < gnt_log.size()) begin
                check($sformatf("fair_gnt%0d", i), 32'(gnt_log[i]), 32'(exp_seq[i]));
                check($sformatf("fair_owner%0d", i), 32'(owner_log[i]), 32'(exp_seq[i]));
            end
        end

        // request during busy, then a withdrawn request
        bytes[0] = 8'h5A;
        g0 = gnt_log.size();
        d0 = done_cnt;
        grant_one(4'b0001, "busy_r0");
        tick_wait(4);
        req = 4'b0100;
        bytes[2] = 8'h3C;
        tick_wait(FT - 4);
        check("busy_r0_done", 32'(done_cnt - d0), 32'd1);
        check("busy_no_early_gnt", 32'(gnt_log.size() - g0), 32'd1);
        wait_gnt("busy_r2");
        req = '0;
        check("busy_r2_idx", 32'(gnt_log[gnt_log.size() - 1]), 32'd2);
        bytes[2] = 8'hFF;
        tx_log.delete();
        tick_wait(3);
        @(negedge clock);
        req = 4'b0010;
        @(negedge clock);
        req = '0;
        tick_wait(FT - 3);
`ifdef UART_TX_PARITY_EN
        exp_seq = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1};
`else
        exp_seq = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1};
`endif
        compare_seq("busy_r2_3c");
        check("busy_r2_done", 32'(done_cnt - d0), 32'd2);
        tx_log.delete();
        tick_wait(3);
        check("withdraw_no_gnt", 32'(gnt_log.size() - g0), 32'd2);
        check("withdraw_idle", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) check($sformatf("withdraw_tx%0d", i), 32'(tx_log[i]), 32'd1);

        // reset during data bit 3
        bytes[0] = 8'hA5;
        grant_one(4'b0001, "midrst");
        tick_wait(5);
        d0 = done_cnt;
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_tx",   32'(tx),   32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_gnt",  32'(gnt),  32'd0);
        check("midrst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        gnt_log.delete();
        owner_log.delete();
        req = 4'b1111;
        wait_gnt("midrst_rr");
        req = '0;
        check("midrst_first_gnt", 32'(gnt_log[0]), 32'd0);
        check("midrst_first_owner", 32'(owner), 32'd0);
        d0 = done_cnt;
        tick_wait(FT + 1);
        check("midrst_drain_done", 32'(done_cnt - d0), 32'd1);

`ifdef UART_TX_PARITY_EN
        // parity frame, 0x07 has odd weight
        bytes[0] = 8'h07;
        grant_one(4'b0001, "par07");
        tx_log.delete();
        d0 = done_cnt;
        tick_wait(FT - 1);
        check("par07_no_early_done", 32'(done_cnt - d0), 32'd0);
        tick_wait(1);
        check("par07_done", 32'(done_cnt - d0), 32'd1);
        exp_seq = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
        compare_seq("par07");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
